circuit5_seq: RTL and testbench

//  Sequential, parametrised successor to the combinational circuit5 datapath.

---
 rtl/circuit5_seq.sv | 213 +++++++++++++++++++++
 tb/tb_circuit5_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/circuit5_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : circuit5_seq
//  Description : Multi-cycle form of the circuit5 datapath.
//                  z = ((a % b) == zero) ? (a / b) : (c / d)
//                One radix-2 restoring divider is shared by both divisions and
//                produces one quotient bit per clock. c / d is evaluated only
//                when the a % b test fails.
//
//  Parameters  : DATAWIDTH  width of a, b, c, d, zero and z (unsigned, >= 2)
//
//  Ports       : Clk                clock, rising edge
//                Rst                asynchronous, active-high reset
//                start              request, sampled only while not busy
//                a, b, c, d, zero   operands, captured on the accepting edge
//                busy               operation in flight
//                done               one-cycle pulse, z/dz valid
//                z                  selected quotient, held until next done
//                dz                 selected quotient came from a zero divisor
//
//  Revision    : 1.0  initial release
// ============================================================================
module circuit5_seq #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    input  logic [DATAWIDTH-1:0] d,
    input  logic [DATAWIDTH-1:0] zero,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] z,
    output logic                 dz
);

    // Counter must be able to hold DATAWIDTH itself (see DIV_CD below).
    localparam int c_CNT_W = $clog2(DATAWIDTH + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATAWIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DATAWIDTH);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_DIV_AB = 3'd1;
    localparam logic [2:0] c_ST_CHK    = 3'd2;
    localparam logic [2:0] c_ST_DIV_CD = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [DATAWIDTH-1:0] r_dividend;   // shifts out dividend, shifts in quotient
    logic [DATAWIDTH-1:0] r_divisor;
    logic [DATAWIDTH:0]   r_rem;        // one spare bit keeps the compare exact
    logic [c_CNT_W-1:0]   r_cnt;
    logic [DATAWIDTH-1:0] r_opC;
    logic [DATAWIDTH-1:0] r_opD;
    logic [DATAWIDTH-1:0] r_zero;
    logic [DATAWIDTH-1:0] r_z;
    logic                 r_dz;

    logic [2:0]           w_stateNext;
    logic [DATAWIDTH-1:0] w_dividendNext;
    logic [DATAWIDTH-1:0] w_divisorNext;
    logic [DATAWIDTH:0]   w_remNext;
    logic [c_CNT_W-1:0]   w_cntNext;
    logic [DATAWIDTH-1:0] w_opCNext;
    logic [DATAWIDTH-1:0] w_opDNext;
    logic [DATAWIDTH-1:0] w_zeroNext;
    logic [DATAWIDTH-1:0] w_zNext;
    logic                 w_dzNext;

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    // Before a step the remainder is below the divisor, so it fits in
    // DATAWIDTH bits; after shifting in the next dividend bit it needs
    // DATAWIDTH+1 bits, which is why the compare is done at that width.
    // A zero divisor makes every step "fit": the quotient becomes all ones
    // and the remainder ends equal to the dividend, with no special casing.
    logic [DATAWIDTH:0]   w_shifted;
    logic                 w_fits;
    logic [DATAWIDTH:0]   w_remStep;
    logic [DATAWIDTH-1:0] w_quotStep;
    logic                 w_accept;

    assign w_shifted  = {r_rem[DATAWIDTH-1:0], r_dividend[DATAWIDTH-1]};
    assign w_fits     = (w_shifted >= {1'b0, r_divisor});
    assign w_remStep  = w_fits ? (w_shifted - {1'b0, r_divisor}) : w_shifted;
    assign w_quotStep = {r_dividend[DATAWIDTH-2:0], w_fits};

    // A new request may be taken in IDLE or in the DONE cycle, which allows
    // back-to-back operations without an idle gap.
    assign w_accept = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext    = r_state;
        w_dividendNext = r_dividend;
        w_divisorNext  = r_divisor;
        w_remNext      = r_rem;
        w_cntNext      = r_cnt;
        w_opCNext      = r_opC;
        w_opDNext      = r_opD;
        w_zeroNext     = r_zero;
        w_zNext        = r_z;
        w_dzNext       = r_dz;

        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                w_stateNext = c_ST_IDLE;
                if (w_accept) begin
                    w_dividendNext = a;
                    w_divisorNext  = b;
                    w_remNext      = '0;
                    w_cntNext      = c_CNT_LAST;
                    w_opCNext      = c;
                    w_opDNext      = d;
                    w_zeroNext     = zero;
                    w_stateNext    = c_ST_DIV_AB;
                end
            end

            c_ST_DIV_AB: begin
                w_dividendNext = w_quotStep;
                w_remNext      = w_remStep;
                w_cntNext      = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_stateNext = c_ST_CHK;
                end
            end

            c_ST_CHK: begin
                // Bit DATAWIDTH of the remainder is always 0 after a step.
                if (r_rem == {1'b0, r_zero}) begin
                    w_zNext     = r_dividend;
                    w_dzNext    = (r_divisor == '0);
                    w_stateNext = c_ST_DONE;
                end else begin
                    w_dividendNext = r_opC;
                    w_divisorNext  = r_opD;
                    w_remNext      = '0;
                    w_cntNext      = c_CNT_FULL;
                    w_stateNext    = c_ST_DIV_CD;
                end
            end

            c_ST_DIV_CD: begin
                // DATAWIDTH shift edges while the count is non-zero, then one
                // result-write edge, mirroring the CHK edge of the fast path.
                if (r_cnt == '0) begin
                    w_zNext     = r_dividend;
                    w_dzNext    = (r_divisor == '0);
                    w_stateNext = c_ST_DONE;
                end else begin
                    w_dividendNext = w_quotStep;
                    w_remNext      = w_remStep;
                    w_cntNext      = r_cnt - 1'b1;
                end
            end

            default: begin
                w_stateNext = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= c_ST_IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_opC      <= '0;
            r_opD      <= '0;
            r_zero     <= '0;
            r_z        <= '0;
            r_dz       <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_dividend <= w_dividendNext;
            r_divisor  <= w_divisorNext;
            r_rem      <= w_remNext;
            r_cnt      <= w_cntNext;
            r_opC      <= w_opCNext;
            r_opD      <= w_opDNext;
            r_zero     <= w_zeroNext;
            r_z        <= w_zNext;
            r_dz       <= w_dzNext;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
    assign done = (r_state == c_ST_DONE);
    assign z    = r_z;
    assign dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_circuit5_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_circuit5_seq
//  Description : Self-checking bench for circuit5_seq. An 8-bit instance takes
//                directed cases and randomised operations; a 64-bit instance
//                takes the wide directed cases. Expected results and latencies
//                come from a plain-arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_circuit5_seq;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    logic       start8;
    logic [7:0] a8, b8, c8, d8, zero8;
    logic       busy8, done8, dz8;
    logic [7:0] z8;

    logic        start64;
    logic [63:0] a64, b64, c64, d64, zero64;
    logic        busy64, done64, dz64;
    logic [63:0] z64;

    circuit5_seq #(.DATAWIDTH(8)) u_dut8 (
        .Clk(Clk), .Rst(Rst), .start(start8),
        .a(a8), .b(b8), .c(c8), .d(d8), .zero(zero8),
        .busy(busy8), .done(done8), .z(z8), .dz(dz8)
    );

    circuit5_seq #(.DATAWIDTH(64)) u_dut64 (
        .Clk(Clk), .Rst(Rst), .start(start64),
        .a(a64), .b(b64), .c(c64), .d(d64), .zero(zero64),
        .busy(busy64), .done(done64), .z(z64), .dz(dz64)
    );

    int          nChecks = 0;
    int          nFails  = 0;
    logic [63:0] lastZ8  = '0;
    logic [63:0] lastZ64 = '0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // z = ((a%b)==zero) ? a/b : c/d, with x/0 = all ones and x%0 = x.
    function automatic void refModel(input int w,
                                     input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] c, input logic [63:0] d,
                                     input logic [63:0] zero,
                                     output logic [63:0] z, output logic dz, output int lat);
        logic [63:0] mask;
        logic [63:0] q;
        logic [63:0] r;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        if (b == 0) begin q = mask; r = a; end
        else        begin q = a / b; r = a % b; end
        if (r == zero) begin
            z = q; dz = (b == 0); lat = w + 1;
        end else begin
            dz = (d == 0); z = (d == 0) ? mask : (c / d); lat = 2 * w + 2;
        end
    endfunction

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [7:0] zero);
        a8 = a; b8 = b; c8 = c; d8 = d; zero8 = zero;
        start8 = 1'b1;
    endtask

    // Called with start8 raised before the accepting edge; returns at #1 after
    // the edge that raises done (i.e. inside the DONE cycle).
    task automatic finish8(input string tag, input bit noisy, input int pulseAt);
        logic [63:0] ez;
        logic        edz;
        int          elat;
        int          n;
        bit          seen;
        refModel(8, 64'(a8), 64'(b8), 64'(c8), 64'(d8), 64'(zero8), ez, edz, elat);
        @(posedge Clk); #1;
        start8 = 1'b0;
        checkVal({tag, "/busy_after_accept"}, 64'(busy8), 64'd1);
        checkVal({tag, "/z_held"}, 64'(z8), lastZ8);
        n = 0;
        seen = 1'b0;
        while (n < 300 && !seen) begin
            @(posedge Clk); n++; #1;
            if (done8) begin
                seen = 1'b1;
            end else if (noisy) begin
                a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
                d8 = 8'($urandom); zero8 = 8'($urandom);
                start8 = ($urandom_range(0, 3) == 0);
            end else if (n == pulseAt) begin
                a8 = 8'd200; b8 = 8'd3; c8 = 8'd50; d8 = 8'd1; zero8 = 8'd2;
                start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        checkVal({tag, "/done_seen"}, 64'(seen), 64'd1);
        checkVal({tag, "/latency"}, 64'(n), 64'(elat));
        checkVal({tag, "/z"}, 64'(z8), ez);
        checkVal({tag, "/dz"}, 64'(dz8), 64'(edz));
        checkVal({tag, "/busy_in_done"}, 64'(busy8), 64'd0);
        lastZ8 = ez;
    endtask

    task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] d, input logic [63:0] zero,
                         input logic [63:0] expZ, input int expLat);
        int n;
        bit seen;
        @(negedge Clk);
        a64 = a; b64 = b; c64 = c; d64 = d; zero64 = zero;
        start64 = 1'b1;
        @(posedge Clk); #1;
        start64 = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 400 && !seen) begin
            @(posedge Clk); n++; #1;
            if (done64) seen = 1'b1;
        end
        checkVal({tag, "/done_seen"}, 64'(seen), 64'd1);
        checkVal({tag, "/latency"}, 64'(n), 64'(expLat));
        checkVal({tag, "/z"}, z64, expZ);
        checkVal({tag, "/dz"}, 64'(dz64), 64'd0);
        lastZ64 = expZ;
    endtask

    initial begin
        Rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; c8 = '0; d8 = '0; zero8 = '0;
        start64 = 1'b0; a64 = '0; b64 = '0; c64 = '0; d64 = '0; zero64 = '0;
        repeat (3) @(posedge Clk);
        #1;
        checkVal("reset/busy", 64'(busy8), 64'd0);
        checkVal("reset/done", 64'(done8), 64'd0);
        checkVal("reset/z", 64'(z8), 64'd0);
        checkVal("reset/dz", 64'(dz8), 64'd0);
        checkVal("reset/z64", z64, 64'd0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        // Slow path: 17%5=2 != 0 -> 100/7 = 14 at E18.
        launch8(8'd17, 8'd5, 8'd100, 8'd7, 8'd0);
        finish8("case1", 1'b0, -1);
        checkVal("case1/z_const", 64'(z8), 64'd14);
        @(negedge Clk);

        // Fast path: 20/5 = 4 at E9.
        launch8(8'd20, 8'd5, 8'd100, 8'd7, 8'd0);
        finish8("case2", 1'b0, -1);
        checkVal("case2/z_const", 64'(z8), 64'd4);
        @(negedge Clk);

        // Matching non-zero remainder and divide-by-zero on the a/b side.
        launch8(8'd17, 8'd5, 8'd100, 8'd7, 8'd2);
        finish8("case3a", 1'b0, -1);
        checkVal("case3a/z_const", 64'(z8), 64'd3);
        @(negedge Clk);
        launch8(8'd9, 8'd0, 8'd100, 8'd7, 8'd9);
        finish8("case3b", 1'b0, -1);
        checkVal("case3b/z_const", 64'(z8), 64'hFF);
        @(negedge Clk);
        launch8(8'd0, 8'd0, 8'd100, 8'd7, 8'd0);
        finish8("case3c", 1'b0, -1);
        @(negedge Clk);

        // Start pulse while busy is ignored, then a back-to-back request
        // raised in the DONE cycle.
        launch8(8'd17, 8'd5, 8'd100, 8'd7, 8'd0);
        finish8("case4", 1'b0, 3);
        launch8(8'd20, 8'd5, 8'd100, 8'd7, 8'd0);
        finish8("case4_b2b", 1'b0, -1);
        @(negedge Clk);

        // Reset mid-operation aborts immediately; next request runs normally.
        launch8(8'd17, 8'd5, 8'd100, 8'd7, 8'd0);
        @(posedge Clk); #1;
        start8 = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        Rst = 1'b1;
        #1;
        checkVal("case5/busy", 64'(busy8), 64'd0);
        checkVal("case5/done", 64'(done8), 64'd0);
        checkVal("case5/z", 64'(z8), 64'd0);
        checkVal("case5/dz", 64'(dz8), 64'd0);
        lastZ8 = '0;
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        launch8(8'd20, 8'd5, 8'd100, 8'd7, 8'd0);
        finish8("case5_restart", 1'b0, -1);
        @(negedge Clk);

        // Wide instance.
        run64("case6a", 64'h8000_0000_0000_0001, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
              64'd0, 64'h2AAA_AAAA_AAAA_AAAB, 65);
        run64("case6b", 64'h8000_0000_0000_0001, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
              64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 130);

        // Randomised operations with noisy inputs while busy.
        @(negedge Clk);
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] ra, rb, rc, rd, rz;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            rc = 8'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 1) == 0) rz = (rb == 0) ? ra : (ra % rb);
            else                           rz = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(1, 2)) @(negedge Clk);
            end
            launch8(ra, rb, rc, rd, rz);
            finish8("rand", 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
